axi_ram_responder: RTL



---
 rtl/axi_ram_responder.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_ram_responder.sv
// axi_ram_responder
// AXI4 slave memory endpoint. Accepts independent write and read bursts
// (FIXED / INCR / WRAP, full-width beats only) against an internal
// byte-strobed RAM of 2^ADDR_WIDTH bytes and returns B / R responses that
// echo the captured transaction ID.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s_axi_aw*                write address channel (id, addr, len, burst)
//   s_axi_w*                 write data channel (data, strb, last)
//   s_axi_b*                 write response channel (id, resp)
//   s_axi_ar*                read address channel (id, addr, len, burst)
//   s_axi_r*                 read data channel (id, data, resp, last)
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds its payload stable
// from the cycle valid rises until that transfer; ready may change freely.
module axi_ram_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - LSB;
    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reserved burst type, or WRAP with an unsupported length.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        burst_bad = (burst == 2'b11) ||
                    (burst == BURST_WRAP && !(len == 8'd1 || len == 8'd3 ||
                                              len == 8'd7 || len == 8'd15));
    endfunction

    // Word index of the following beat. WRAP keeps the upper bits of the
    // index and increments only inside the (len+1)-word aligned block.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] burst,
                                                  input logic [7:0] len);
        logic [IDX_W-1:0] mask;
        logic [IDX_W-1:0] inc;
        mask = IDX_W'(len);
        inc  = idx + 1'b1;
        case (burst)
            BURST_FIXED: next_idx = idx;
            BURST_WRAP:  next_idx = (idx & ~mask) | (inc & mask);
            default:     next_idx = inc;
        endcase
    endfunction

    // ---------------- write path ----------------
    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len;
    logic [7:0]       w_cnt;
    logic [1:0]       w_burst;
    logic             w_err;
    logic             w_fire;

    assign w_fire = s_axi_wvalid && s_axi_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= RESP_OKAY;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= BURST_INCR;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awready && s_axi_awvalid) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        s_axi_bid     <= s_axi_awid;
                        w_idx         <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
                        w_len         <= s_axi_awlen;
                        w_cnt         <= '0;
                        w_err         <= burst_bad(s_axi_awburst, s_axi_awlen);
                        w_burst       <= burst_bad(s_axi_awburst, s_axi_awlen) ?
                                         BURST_INCR : s_axi_awburst;
                        w_state       <= W_DATA;
                    end else begin
                        // Also raises awready on the first edge after reset.
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_idx <= next_idx(w_idx, w_burst, w_len);
                        if (w_cnt == w_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state      <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                            if (s_axi_wlast) w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RAM has no reset; wready is forced low by reset, so no write can occur then.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;      // index of the next word to load
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;
    logic [1:0]       r_burst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= BURST_INCR;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rid     <= s_axi_arid;
                        // Same-edge write to this word lands after this read: old data.
                        s_axi_rdata   <= mem[s_axi_araddr[ADDR_WIDTH-1:LSB]];
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rresp   <= burst_bad(s_axi_arburst, s_axi_arlen) ?
                                         RESP_SLVERR : RESP_OKAY;
                        r_burst       <= burst_bad(s_axi_arburst, s_axi_arlen) ?
                                         BURST_INCR : s_axi_arburst;
                        r_idx         <= next_idx(s_axi_araddr[ADDR_WIDTH-1:LSB],
                                                  burst_bad(s_axi_arburst, s_axi_arlen) ?
                                                  BURST_INCR : s_axi_arburst,
                                                  s_axi_arlen);
                        r_len         <= s_axi_arlen;
                        r_cnt         <= '0;
                        r_state       <= R_DATA;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= mem[r_idx];
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                            r_idx       <= next_idx(r_idx, r_burst, r_len);
                            r_cnt       <= r_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Sub-word address bits are ignored: every beat is full width.
    generate
        if (LSB > 0) begin : g_lsbs
            logic unused_addr_lsbs;
            assign unused_addr_lsbs = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};
        end
    endgenerate

endmodule
